// File: rtl/riscv_div_unit.sv
// Multi-cycle restoring divider for RV64M/RV32M DIV/DIVU/REM/REMU and W variants.
// Latency: XLEN+1 cycles full, 33 word, 1 for divide-by-zero / signed overflow.
// Backpressure: ready only in IDLE; start while busy is ignored, kill aborts.
module riscv_div_unit #(
    parameter int XLEN      = 64,
    parameter bit SUPPORT_W = 1'b1
) (
    input  logic            i_riscv_div_clk,
    input  logic            i_riscv_div_rst_n,
    input  logic            i_riscv_div_start,
    input  logic [2:0]      i_riscv_div_op,
    input  logic [XLEN-1:0] i_riscv_div_rs1data,
    input  logic [XLEN-1:0] i_riscv_div_rs2data,
    input  logic            i_riscv_div_kill,
    output logic            o_riscv_div_ready,
    output logic            o_riscv_div_valid,
    output logic [XLEN-1:0] o_riscv_div_result
);

    localparam int CW = $clog2(XLEN) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam bit W_EN = SUPPORT_W && (XLEN == 64);

    localparam logic [CW-1:0] LAST_FULL = CW'(XLEN - 1);
    localparam logic [CW-1:0] LAST_WORD = CW'(31);

    // Replace bits above 31 with bit 31 (sx=1) or zeros (sx=0).
    function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] x, input logic sx);
        logic [XLEN-1:0] r;
        r = x;
        for (int i = 32; i < XLEN; i++) begin
            r[i] = sx & x[31];
        end
        return r;
    endfunction

    logic [1:0]      state_q,     state_d;
    logic [CW-1:0]   cnt_q,       cnt_d;
    logic [XLEN-1:0] rem_q,       rem_d;
    logic [XLEN-1:0] quot_q,      quot_d;
    logic [XLEN-1:0] divisor_q,   divisor_d;
    logic [XLEN-1:0] result_q,    result_d;
    logic            is_rem_q,    is_rem_d;
    logic            is_word_q,   is_word_d;
    logic            neg_quo_q,   neg_quo_d;
    logic            neg_rem_q,   neg_rem_d;

    logic            accept;
    logic            req_rem, req_signed, req_word;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] min_val;
    logic            div_zero, sgn_ovf;
    logic [XLEN-1:0] early_raw, early_res, quot_init;

    logic [XLEN:0]   rem_sh, dvs_ext, diff;
    logic            take;
    logic [XLEN-1:0] rem_nx, quot_nx;
    logic [XLEN-1:0] sel, sel_sgn, fin_res;
    logic            sel_neg;
    logic [CW-1:0]   iter_last;

    assign accept = i_riscv_div_start && (state_q == S_IDLE) && !i_riscv_div_kill;

    // Operand preparation on the live request inputs.
    always_comb begin
        req_rem    = i_riscv_div_op[2];
        req_signed = ~i_riscv_div_op[1];
        req_word   = W_EN && i_riscv_div_op[0];

        a_ext = req_word ? ext32(i_riscv_div_rs1data, req_signed) : i_riscv_div_rs1data;
        b_ext = req_word ? ext32(i_riscv_div_rs2data, req_signed) : i_riscv_div_rs2data;

        a_neg = req_signed & a_ext[XLEN-1];
        b_neg = req_signed & b_ext[XLEN-1];
        a_mag = a_neg ? -a_ext : a_ext;
        b_mag = b_neg ? -b_ext : b_ext;

        min_val  = req_word ? ext32(XLEN'(32'h8000_0000), 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = (b_ext == '0);
        sgn_ovf  = req_signed && (a_ext == min_val) && (b_ext == '1);

        if (div_zero) begin
            early_raw = req_rem ? a_ext : '1;
        end else begin
            early_raw = req_rem ? '0 : a_ext;
        end
        early_res = req_word ? ext32(early_raw, 1'b1) : early_raw;

        // Word dividends sit in the top half so 32 shifts consume them fully.
        quot_init = req_word ? (a_mag << (XLEN - 32)) : a_mag;
    end

    // One restoring step; the XLEN+1 wide compare covers a divisor with MSB set.
    always_comb begin
        rem_sh  = {rem_q, quot_q[XLEN-1]};
        dvs_ext = {1'b0, divisor_q};
        take    = (rem_sh >= dvs_ext);
        diff    = rem_sh - dvs_ext;
        rem_nx  = XLEN'(take ? diff : rem_sh);
        quot_nx = {quot_q[XLEN-2:0], take};

        sel     = is_rem_q ? rem_nx : quot_nx;
        sel_neg = is_rem_q ? neg_rem_q : neg_quo_q;
        sel_sgn = sel_neg ? -sel : sel;
        fin_res = is_word_q ? ext32(sel_sgn, 1'b1) : sel_sgn;

        iter_last = is_word_q ? LAST_WORD : LAST_FULL;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        divisor_d = divisor_q;
        result_d  = result_q;
        is_rem_d  = is_rem_q;
        is_word_d = is_word_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    is_rem_d  = req_rem;
                    is_word_d = req_word;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    cnt_d     = '0;
                    rem_d     = '0;
                    quot_d    = quot_init;
                    divisor_d = b_mag;
                    if (div_zero || sgn_ovf) begin
                        result_d = early_res;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (i_riscv_div_kill) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    rem_d  = rem_nx;
                    quot_d = quot_nx;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == iter_last) begin
                        result_d = fin_res;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_riscv_div_clk or negedge i_riscv_div_rst_n) begin
        if (!i_riscv_div_rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
            result_q  <= '0;
            is_rem_q  <= 1'b0;
            is_word_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            divisor_q <= divisor_d;
            result_q  <= result_d;
            is_rem_q  <= is_rem_d;
            is_word_q <= is_word_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign o_riscv_div_ready  = (state_q == S_IDLE);
    assign o_riscv_div_valid  = (state_q == S_DONE) && !i_riscv_div_kill;
    assign o_riscv_div_result = result_q;

endmodule

// File: tb/tb_riscv_div_unit.sv
// Self-checking bench for riscv_div_unit (XLEN=64, SUPPORT_W=1) against a plain arithmetic model.
module tb_riscv_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        kill;
    logic [2:0]  op_in;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic        ready;
    logic        valid;
    logic [63:0] result;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [63:0] last_res;

    localparam logic [2:0] OP_DIV   = 3'b000;
    localparam logic [2:0] OP_DIVW  = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_DIVUW = 3'b011;
    localparam logic [2:0] OP_REM   = 3'b100;
    localparam logic [2:0] OP_REMW  = 3'b101;
    localparam logic [2:0] OP_REMU  = 3'b110;

    riscv_div_unit #(.XLEN(64), .SUPPORT_W(1'b1)) dut (
        .i_riscv_div_clk     (clk),
        .i_riscv_div_rst_n   (rst_n),
        .i_riscv_div_start   (start),
        .i_riscv_div_op      (op_in),
        .i_riscv_div_rs1data (rs1),
        .i_riscv_div_rs2data (rs2),
        .i_riscv_div_kill    (kill),
        .o_riscv_div_ready   (ready),
        .o_riscv_div_valid   (valid),
        .o_riscv_div_result  (result)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vec_cnt);
        $fatal(1, "watchdog");
    end

    // RISC-V M-extension semantics in plain arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic        is_rem, is_uns;
        logic [31:0] a32, b32, r32;
        int          sa32, sb32;
        longint      sa, sb;
        logic [63:0] r;
        is_rem = op[2];
        is_uns = op[1];
        if (op[0]) begin
            a32 = a[31:0];
            b32 = b[31:0];
            sa32 = a32;
            sb32 = b32;
            if (b32 == 32'd0) r32 = is_rem ? a32 : 32'hFFFF_FFFF;
            else if (!is_uns && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = is_rem ? 32'd0 : a32;
            else if (is_uns) r32 = is_rem ? (a32 % b32) : (a32 / b32);
            else r32 = is_rem ? 32'(sa32 % sb32) : 32'(sa32 / sb32);
            r = {{32{r32[31]}}, r32};
        end else begin
            sa = a;
            sb = b;
            if (b == 64'd0) r = is_rem ? a : '1;
            else if (!is_uns && a == 64'h8000_0000_0000_0000 && b == '1) r = is_rem ? 64'd0 : a;
            else if (is_uns) r = is_rem ? (a % b) : (a / b);
            else r = is_rem ? 64'(sa % sb) : 64'(sa / sb);
        end
        return r;
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        if (op[0]) begin
            if (b[31:0] == 32'd0) return 1;
            if (!op[1] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
            return 33;
        end
        if (b == 64'd0) return 1;
        if (!op[1] && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
        return 65;
    endfunction

    function automatic logic [63:0] rand_operand();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0: v = 64'd0;
            1: v = '1;
            2: v = 64'h8000_0000_0000_0000;
            3: v = {$urandom, 32'h8000_0000};
            4: v = 64'($urandom_range(1, 20));
            5: v = -64'($urandom_range(1, 20));
            default: begin
                v = {$urandom, $urandom};
                v = v >> $urandom_range(0, 63);
            end
        endcase
        return v;
    endfunction

    // Called at a negedge; waits for ready, then presents one request for one edge.
    task automatic issue(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        op_in = o;
        rs1   = a;
        rs2   = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts cycles after the accept edge; lat=-1 if valid never arrives.
    task automatic wait_valid(output logic [63:0] res, output int lat);
        res = '0;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                res = result;
                lat = n;
                break;
            end
            rs1   = {$urandom, $urandom};
            rs2   = {$urandom, $urandom};
            op_in = 3'($urandom);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        kill  = 1'b0;
        op_in = 3'd0;
        rs1   = '0;
        rs2   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vec_cnt++;
        if (ready !== 1'b1) begin err_cnt++; $display("FAIL reset_ready got=%b exp=1", ready); end
        vec_cnt++;
        if (valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid got=%b exp=0", valid); end
        vec_cnt++;
        if (result !== 64'd0) begin err_cnt++; $display("FAIL reset_result got=%h exp=0", result); end
        rst_n = 1'b1;
        last_res = '0;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [2:0]  t_op  [11];
        logic [63:0] t_a   [11];
        logic [63:0] t_b   [11];
        logic [63:0] t_exp [11];
        int          t_lat [11];
        logic [63:0] r;
        int          lat;
        t_op  = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REMW,
                  OP_DIV, OP_REM, OP_DIVW, OP_DIVUW, OP_DIVW};
        t_a   = '{-64'sd7, -64'sd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5,
                  64'h1_8000_0005, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                  64'h8000_0000, 64'hFFFF_FFFF, 64'hABCD_0000_0000_0064};
        t_b   = '{64'd2, 64'd2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0,
                  64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'hFFFF_FFFF, 64'd1, 64'd7};
        t_exp = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF,
                  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0005, 64'h8000_0000_0000_0000,
                  64'd0, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd14};
        t_lat = '{65, 65, 65, 65, 1, 1, 1, 1, 1, 33, 33};
        for (int i = 0; i < 11; i++) begin
            issue(t_op[i], t_a[i], t_b[i]);
            wait_valid(r, lat);
            vec_cnt++;
            if (r !== t_exp[i]) begin
                err_cnt++;
                $display("FAIL directed[%0d] result got=%h exp=%h", i, r, t_exp[i]);
            end
            vec_cnt++;
            if (lat != t_lat[i]) begin
                err_cnt++;
                $display("FAIL directed[%0d] latency got=%0d exp=%0d", i, lat, t_lat[i]);
            end
            last_res = t_exp[i];
            @(negedge clk);
        end
    endtask

    task automatic test_random;
        logic [2:0]  o;
        logic [63:0] a, b, r, e;
        int          lat, el;
        for (int i = 0; i < 60; i++) begin
            o  = 3'($urandom);
            a  = rand_operand();
            b  = rand_operand();
            e  = ref_result(o, a, b);
            el = ref_latency(o, a, b);
            issue(o, a, b);
            wait_valid(r, lat);
            vec_cnt++;
            if (r !== e) begin
                err_cnt++;
                $display("FAIL random[%0d] op=%b a=%h b=%h got=%h exp=%h", i, o, a, b, r, e);
            end
            vec_cnt++;
            if (lat != el) begin
                err_cnt++;
                $display("FAIL random[%0d] latency op=%b got=%0d exp=%0d", i, o, lat, el);
            end
            @(negedge clk);
            vec_cnt++;
            if (valid !== 1'b0 || ready !== 1'b1) begin
                err_cnt++;
                $display("FAIL random[%0d] post_valid valid=%b ready=%b exp valid=0 ready=1", i, valid, ready);
            end
            last_res = e;
        end
    endtask

    task automatic test_kill_accept;
        op_in = OP_DIV;
        rs1   = 64'd9;
        rs2   = 64'd0;
        start = 1'b1;
        kill  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        kill = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if (valid !== 1'b0) begin err_cnt++; $display("FAIL kill_accept valid got=%b exp=0", valid); end
        vec_cnt++;
        if (ready !== 1'b1) begin err_cnt++; $display("FAIL kill_accept ready got=%b exp=1", ready); end
        vec_cnt++;
        if (result !== last_res) begin err_cnt++; $display("FAIL kill_accept result got=%h exp=%h", result, last_res); end
    endtask

    task automatic test_kill_calc;
        logic [63:0] r, e;
        int          lat;
        bit          seen;
        seen = 1'b0;
        issue(OP_DIV, 64'd1000, 64'd3);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (valid === 1'b1) seen = 1'b1;
        end
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if (seen !== 1'b0 || valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL kill_calc valid_seen=%b valid=%b exp 0", seen, valid);
        end
        vec_cnt++;
        if (ready !== 1'b1) begin err_cnt++; $display("FAIL kill_calc ready got=%b exp=1", ready); end
        vec_cnt++;
        if (result !== last_res) begin err_cnt++; $display("FAIL kill_calc result got=%h exp=%h", result, last_res); end
        e = ref_result(OP_REM, -64'sd1000, 64'd3);
        issue(OP_REM, -64'sd1000, 64'd3);
        wait_valid(r, lat);
        vec_cnt++;
        if (r !== e) begin err_cnt++; $display("FAIL kill_followup result got=%h exp=%h", r, e); end
        vec_cnt++;
        if (lat != 65) begin err_cnt++; $display("FAIL kill_followup latency got=%0d exp=65", lat); end
        last_res = e;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [63:0] r;
        int          lat;
        issue(OP_DIVU, 64'd1000, 64'd7);
        wait_valid(r, lat);
        vec_cnt++;
        if (r !== 64'd142 || lat != 65) begin
            err_cnt++;
            $display("FAIL b2b_first got=%h lat=%0d exp=%h lat=65", r, lat, 64'd142);
        end
        // Second request presented while valid is high: must wait one cycle.
        op_in = OP_DIV;
        rs1   = 64'd100;
        rs2   = -64'sd7;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vec_cnt++;
        if (valid !== 1'b0 || ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL b2b_gap valid=%b ready=%b exp valid=0 ready=1", valid, ready);
        end
        @(posedge clk);
        #1 start = 1'b0;
        wait_valid(r, lat);
        vec_cnt++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFF2) begin
            err_cnt++;
            $display("FAIL b2b_second result got=%h exp=%h", r, 64'hFFFF_FFFF_FFFF_FFF2);
        end
        vec_cnt++;
        if (lat != 65) begin err_cnt++; $display("FAIL b2b_second latency got=%0d exp=65", lat); end
        last_res = 64'hFFFF_FFFF_FFFF_FFF2;
        @(negedge clk);
    endtask

    task automatic test_kill_done;
        issue(OP_DIVU, 64'd5, 64'd0);
        @(negedge clk);
        kill = 1'b1;
        #1;
        vec_cnt++;
        if (valid !== 1'b0) begin err_cnt++; $display("FAIL kill_done valid got=%b exp=0", valid); end
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if (ready !== 1'b1 || valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL kill_done after ready=%b valid=%b exp ready=1 valid=0", ready, valid);
        end
    endtask

    task automatic test_reset_mid;
        logic [63:0] r, e;
        int          lat;
        issue(OP_DIV, 64'd123456789, 64'd5);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (valid !== 1'b0) begin err_cnt++; $display("FAIL reset_mid valid got=%b exp=0", valid); end
        vec_cnt++;
        if (result !== 64'd0) begin err_cnt++; $display("FAIL reset_mid result got=%h exp=0", result); end
        vec_cnt++;
        if (ready !== 1'b1) begin err_cnt++; $display("FAIL reset_mid ready got=%b exp=1", ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        e = ref_result(OP_DIVW, 64'hFFFF_FFFF_FFFF_FF9C, 64'd9);
        issue(OP_DIVW, 64'hFFFF_FFFF_FFFF_FF9C, 64'd9);
        wait_valid(r, lat);
        vec_cnt++;
        if (r !== e || lat != 33) begin
            err_cnt++;
            $display("FAIL reset_recover got=%h lat=%0d exp=%h lat=33", r, lat, e);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_kill_accept();
        test_kill_calc();
        test_back_to_back();
        test_kill_done();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/riscv_div_unit.md
Name: riscv_div_unit

Overview:
- Parametrised, multi-cycle restoring divider for the RV64M/RV32M execute stage: DIV, DIVU, REM, REMU and the W variants.
- Operands and op are latched on a valid/ready handshake, so results no longer depend on live inputs.
- Zero-divisor and signed-overflow results complete early.
- Supports a pipeline kill (flush) mid-operation.

Parameters:
- XLEN, 64, operand/result width; legal values 32 or 64.
- SUPPORT_W, 1, enables word ops (DIVW/DIVUW/REMW/REMUW); legal only when XLEN=64. When 0, i_riscv_div_op[0] is ignored.

Ports:
- i_riscv_div_clk  in  1  clock.
- i_riscv_div_rst_n  in  1  asynchronous active-low reset.
- i_riscv_div_start  in  1  request valid; accepted when start && o_riscv_div_ready.
- i_riscv_div_op  in  3  {is_rem, is_unsigned, is_word}.
- i_riscv_div_rs1data  in  XLEN  dividend.
- i_riscv_div_rs2data  in  XLEN  divisor.
- i_riscv_div_kill  in  1  abort the in-flight op.
- o_riscv_div_ready  out  1  high only in IDLE.
- o_riscv_div_valid  out  1  one-cycle result strobe.
- o_riscv_div_result  out  XLEN  result, held until the next accept.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ready=1, valid=0, result=0, iteration counter=0. All internal operand and remainder registers are cleared.
- States:
  - IDLE: wait for accept.
  - CALC: one quotient bit per cycle.
  - DONE: output cycle.
- Accept (edge E0), operand preparation:
  - Latch op. Word ops take the low 32 bits of each operand, sign-extended if signed, zero-extended if unsigned.
  - Signed ops record neg_q = sign(a) XOR sign(b) and neg_r = sign(a), then divide magnitudes (two's complement negate).
  - Unsigned ops use operands as-is; the datapath is XLEN+1 bits wide so the divisor MSB=1 needs no special case.
- Early cases at accept go straight to DONE, so valid is high in the cycle after E0:
  - Divisor==0: quotient = all ones (XLEN bits); remainder = prepared dividend.
  - Signed and dividend==MIN and divisor==-1: quotient = MIN; remainder = 0. MIN is -2^(XLEN-1), or -2^31 for word ops.
- CALC:
  - ITER = XLEN for full ops, 32 for word ops.
  - Each cycle: shift {rem,quot} left by 1; trial = rem - divisor. If trial is non-negative, rem = trial and the quotient LSB = 1; otherwise restore and the LSB = 0.
  - After ITER cycles in CALC, move to DONE.
- Latency: normal op valid is high in cycle E0+ITER+1, i.e. 65 cycles for XLEN=64 full and 33 for word ops.
- DONE, result register loaded on entry:
  - Selects quotient or remainder and applies the neg_q/neg_r negation.
  - Word ops sign-extend bit 31 to XLEN, for unsigned W ops as well.
  - Then returns to IDLE; ready=1 in the cycle after valid.
- Kill:
  - In CALC: abort and go to IDLE next cycle. No valid is issued; result keeps its previous value.
  - In DONE: suppress valid.
  - Kill in the same cycle as accept: the accept is discarded.
  - Kill in IDLE: no effect.
- Back-to-back: a new start while valid is high is not accepted, because ready=0. Earliest re-accept is the cycle after valid.
- Start while not ready: ignored. No queuing; the requester holds start until ready.
- Reset mid-operation: immediate return to reset values; no valid.
- No X propagation: the result is only updated in DONE.

Test Plan:
- DIV, XLEN=64: rs1=-7, rs2=2 -> valid at E0+65, result=0xFFFF_FFFF_FFFF_FFFD (-3). REM on the same operands -> 0xFFFF_FFFF_FFFF_FFFF (-1).
- DIVU: rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=0x8000_0000_0000_0000 -> result=1. REMU on the same operands -> 0x7FFF_FFFF_FFFF_FFFF.
- Divide by zero:
  - DIV rs1=5, rs2=0 -> result=all ones, valid at E0+1.
  - REMW rs1=0x1_8000_0005, rs2=0x1_0000_0000 -> 0xFFFF_FFFF_8000_0005.
- Overflow:
  - DIV rs1=0x8000_0000_0000_0000, rs2=-1 -> 0x8000_0000_0000_0000 at E0+1; REM on the same operands -> 0.
  - DIVW rs1=0x8000_0000, rs2=0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000.
- Word ops:
  - DIVUW rs1=0xFFFF_FFFF, rs2=1 -> 0xFFFF_FFFF_FFFF_FFFF at E0+33.
  - DIVW rs1=0xABCD_0000_0000_0064, rs2=7 -> 14.
- Kill/reset:
  - Kill at E0+10 -> no valid, ready=1 at E0+11, result unchanged.
  - A second op accepted immediately after the kill completes correctly.
  - rst_n low mid-CALC -> valid=0, result=0 asynchronously.
